// File: rtl/ram_multi_read_port.sv
// ram_multi_read_port
//   Register-file style data RAM with READ_PORTS registered read ports, a
//   primary write port, an auxiliary write port pinned to AUX_ADDR, optional
//   same-cycle write-to-read bypass, sticky range checking and a sequential
//   clear engine that zeroes the array after reset or on request.
//
// Ports
//   Clock          rising-edge clock
//   Reset          synchronous active-low reset
//   iClear         pulse: start a clear sweep (ignored while busy)
//   iWriteEnable   primary write strobe
//   iWriteAddress  primary write address
//   iDataIn        primary write data
//   iAuxEnable     auxiliary write strobe (writes AUX_ADDR)
//   iDataInAux     auxiliary write data
//   iReadAddress   packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       packed registered read data, same packing
//   oBusy          clear sweep in progress
//   oRangeError    sticky: a primary write or read hit an address >= MEM_DEPTH
module ram_multi_read_port #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 9,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned AUX_ADDR   = 8,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iClear,
  input  logic                             iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic                             iAuxEnable,
  input  logic [DATA_WIDTH-1:0]            iDataInAux,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic                             oBusy,
  output logic                             oRangeError
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Depth held one bit wider than an address so MEM_DEPTH == 2**ADDR_WIDTH fits.
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AUX_A     = ADDR_WIDTH'(AUX_ADDR);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 state, next_state;
  logic [ADDR_WIDTH-1:0]  count, next_count;
  logic                   next_busy;
  logic                   next_err;
  logic [READ_PORTS*DATA_WIDTH-1:0] next_data;

  logic                   clr_we, pri_we, aux_we;
  logic                   wr_in_range;

  logic [DATA_WIDTH-1:0]  ram [MEM_DEPTH];

  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [READ_PORTS-1:0]                 rd_in_range;

  // Unpack read addresses and range-check each port.
  assign rd_addr = iReadAddress;

  always_comb begin
    for (int p = 0; p < int'(READ_PORTS); p++) begin
      rd_in_range[p] = ({1'b0, rd_addr[p]} < DEPTH_LIM);
    end
  end

  assign wr_in_range = ({1'b0, iWriteAddress} < DEPTH_LIM);

  // State, counter and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= CLEAR;
      count       <= '0;
      oBusy       <= 1'b1;
      oDataOut    <= '0;
      oRangeError <= 1'b0;
    end else begin
      state       <= next_state;
      count       <= next_count;
      oBusy       <= next_busy;
      oDataOut    <= next_data;
      oRangeError <= next_err;
    end
  end

  // Next-state, write strobes and next read data.
  always_comb begin
    next_state = state;
    next_count = count;
    next_busy  = oBusy;
    next_err   = oRangeError;
    next_data  = '0;
    clr_we     = 1'b0;
    pri_we     = 1'b0;
    aux_we     = 1'b0;

    case (state)
      CLEAR: begin
        clr_we     = 1'b1;
        next_count = count + ADDR_WIDTH'(1);
        if (count == LAST_ADDR) begin
          next_state = READY;
          next_busy  = 1'b0;
          next_count = '0;
        end
      end

      READY: begin
        if (iClear) begin
          // Accepting edge: no write, read lanes go to 0, error left alone.
          next_state = CLEAR;
          next_count = '0;
          next_busy  = 1'b1;
        end else begin
          aux_we = iAuxEnable;
          // Aux wins a same-address collision, so the primary write is dropped.
          pri_we = iWriteEnable && wr_in_range &&
                   !(iAuxEnable && (iWriteAddress == AUX_A));
          if (iWriteEnable && !wr_in_range) begin
            next_err = 1'b1;
          end
          for (int p = 0; p < int'(READ_PORTS); p++) begin
            if (!rd_in_range[p]) begin
              next_err = 1'b1;
            end else if (BYPASS && aux_we && (rd_addr[p] == AUX_A)) begin
              next_data[p*DATA_WIDTH +: DATA_WIDTH] = iDataInAux;
            end else if (BYPASS && pri_we && (rd_addr[p] == iWriteAddress)) begin
              next_data[p*DATA_WIDTH +: DATA_WIDTH] = iDataIn;
            end else begin
              next_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[IDX_W'(rd_addr[p])];
            end
          end
        end
      end

      default: begin
        next_state = CLEAR;
        next_count = '0;
        next_busy  = 1'b1;
      end
    endcase
  end

  // Storage array; contents are not reset, the sweep zeroes them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (clr_we) begin
        ram[IDX_W'(count)] <= '0;
      end else begin
        if (pri_we) begin
          ram[IDX_W'(iWriteAddress)] <= iDataIn;
        end
        if (aux_we) begin
          ram[IDX_W'(AUX_A)] <= iDataInAux;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_multi_read_port.sv
// Directed testbench for ram_multi_read_port: a default build (2 ports,
// bypass on) and a 4-port no-bypass build share control and write inputs.
module tb_ram_multi_read_port;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iClear = 1'b0;
  logic        iWriteEnable = 1'b0;
  logic [7:0]  iWriteAddress = '0;
  logic [15:0] iDataIn = '0;
  logic        iAuxEnable = 1'b0;
  logic [15:0] iDataInAux = '0;

  logic [15:0] rd_addr = '0;
  logic [31:0] dout;
  logic        busy, err;

  logic [31:0] rd_addr4 = '0;
  logic [63:0] dout4;
  logic        busy4, err4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  ram_multi_read_port u_dut (
    .Clock(Clock), .Reset(Reset), .iClear(iClear),
    .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iDataIn(iDataIn),
    .iAuxEnable(iAuxEnable), .iDataInAux(iDataInAux),
    .iReadAddress(rd_addr), .oDataOut(dout), .oBusy(busy), .oRangeError(err)
  );

  ram_multi_read_port #(.READ_PORTS(4), .BYPASS(1'b0)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .iClear(iClear),
    .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iDataIn(iDataIn),
    .iAuxEnable(iAuxEnable), .iDataInAux(iDataInAux),
    .iReadAddress(rd_addr4), .oDataOut(dout4), .oBusy(busy4), .oRangeError(err4)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Advance until the sweep ends; n = edges taken, capped at 30.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b1 || busy4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy, busy4);
    end
    n_tests++;
    if (dout !== 32'h0 || dout4 !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h expected 0", dout, dout4);
    end
    n_tests++;
    if (err !== 1'b0 || err4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b/%b expected 0/0", err, err4);
    end
    // Release and attempt writes throughout the sweep; all must be ignored.
    Reset = 1'b1;
    iWriteEnable = 1'b1; iWriteAddress = 8'd0; iDataIn = 16'hDEAD;
    iAuxEnable = 1'b1;   iDataInAux = 16'h7777;
    wait_idle(n);
    iWriteEnable = 1'b0; iAuxEnable = 1'b0;
    n_tests++;
    if (n !== 9) begin
      n_fail++; $display("FAIL sweep_len: got %0d expected 9", n);
    end
    n_tests++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL sweep_busy4: got %b expected 0", busy4);
    end
    for (int i = 0; i < 9; i++) begin
      rd_addr  = {8'(8 - i), 8'(i)};
      rd_addr4 = {8'(i), 8'(i), 8'(i), 8'(i)};
      tick();
      n_tests++;
      if (dout !== 32'h0 || dout4 !== 64'h0) begin
        n_fail++; $display("FAIL sweep_zero[%0d]: got %h/%h expected 0", i, dout, dout4);
      end
    end
  endtask

  task automatic test_write_read();
    iWriteEnable = 1'b1; iWriteAddress = 8'd3; iDataIn = 16'h1234;
    tick();
    iWriteAddress = 8'd5; iDataIn = 16'hBEEF;
    tick();
    iWriteEnable = 1'b0;
    rd_addr = {8'd5, 8'd3};
    tick();
    n_tests++;
    if (dout !== {16'hBEEF, 16'h1234}) begin
      n_fail++; $display("FAIL write_read: got %h expected beef1234", dout);
    end
  endtask

  task automatic test_conflict();
    iWriteEnable = 1'b1; iWriteAddress = 8'd8; iDataIn = 16'h1111;
    iAuxEnable = 1'b1;   iDataInAux = 16'h2222;
    tick();
    iWriteEnable = 1'b0; iAuxEnable = 1'b0;
    rd_addr = {8'd0, 8'd8};
    tick();
    n_tests++;
    if (dout[15:0] !== 16'h2222) begin
      n_fail++; $display("FAIL conflict_data: got %h expected 2222", dout[15:0]);
    end
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL conflict_err: got %b expected 0", err);
    end
  endtask

  task automatic test_bypass();
    iWriteEnable = 1'b1; iWriteAddress = 8'd2; iDataIn = 16'hA5A5;
    rd_addr = {8'd0, 8'd2}; rd_addr4 = {8'd0, 8'd0, 8'd0, 8'd2};
    tick();
    iWriteEnable = 1'b0;
    n_tests++;
    if (dout[15:0] !== 16'hA5A5) begin
      n_fail++; $display("FAIL bypass_on: got %h expected a5a5", dout[15:0]);
    end
    n_tests++;
    if (dout4[15:0] !== 16'h0000) begin
      n_fail++; $display("FAIL bypass_off: got %h expected 0000", dout4[15:0]);
    end
    tick();
    n_tests++;
    if (dout4[15:0] !== 16'hA5A5) begin
      n_fail++; $display("FAIL bypass_off_repeat: got %h expected a5a5", dout4[15:0]);
    end
    // Aux takes forwarding priority over primary on the same address.
    iWriteEnable = 1'b1; iWriteAddress = 8'd8; iDataIn = 16'h3333;
    iAuxEnable = 1'b1;   iDataInAux = 16'h4444;
    rd_addr = {8'd8, 8'd0}; rd_addr4 = {8'd0, 8'd0, 8'd8, 8'd0};
    tick();
    iWriteEnable = 1'b0; iAuxEnable = 1'b0;
    n_tests++;
    if (dout[31:16] !== 16'h4444) begin
      n_fail++; $display("FAIL bypass_aux_prio: got %h expected 4444", dout[31:16]);
    end
    n_tests++;
    if (dout4[31:16] !== 16'h2222) begin
      n_fail++; $display("FAIL bypass_off_aux: got %h expected 2222", dout4[31:16]);
    end
    tick();
    n_tests++;
    if (dout4[31:16] !== 16'h4444) begin
      n_fail++; $display("FAIL bypass_off_aux_repeat: got %h expected 4444", dout4[31:16]);
    end
  endtask

  task automatic test_range();
    logic [15:0] exp_mem [9];
    int n;
    exp_mem = '{16'h0, 16'h0, 16'hA5A5, 16'h1234, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h4444};
    // Out-of-range read on the 2-port build only.
    rd_addr = {8'd0, 8'd200}; rd_addr4 = '0;
    tick();
    n_tests++;
    if (dout[15:0] !== 16'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL range_read: got data %h err %b expected 0000 1", dout[15:0], err);
    end
    n_tests++;
    if (err4 !== 1'b0) begin
      n_fail++; $display("FAIL range_read_other: got %b expected 0", err4);
    end
    rd_addr = '0;
    iWriteEnable = 1'b1; iWriteAddress = 8'd9; iDataIn = 16'hFFFF;
    tick();
    iWriteEnable = 1'b0;
    n_tests++;
    if (err4 !== 1'b1) begin
      n_fail++; $display("FAIL range_write: got %b expected 1", err4);
    end
    for (int i = 0; i < 9; i++) begin
      rd_addr  = {8'(i), 8'(i)};
      rd_addr4 = {8'(i), 8'(i), 8'(i), 8'(i)};
      tick();
      n_tests++;
      if (dout !== {2{exp_mem[i]}} || dout4 !== {4{exp_mem[i]}}) begin
        n_fail++; $display("FAIL range_contents[%0d]: got %h/%h expected %h", i, dout, dout4, exp_mem[i]);
      end
    end
    // Clear request: lanes read 0 on the accepting edge, error stays set.
    iClear = 1'b1; rd_addr = {8'd3, 8'd3};
    tick();
    iClear = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || dout !== 32'h0) begin
      n_fail++; $display("FAIL clear_accept: got busy %b data %h expected 1 0", busy, dout);
    end
    wait_idle(n);
    n_tests++;
    if (n !== 9) begin
      n_fail++; $display("FAIL clear_len: got %0d expected 9", n);
    end
    n_tests++;
    if (err !== 1'b1 || err4 !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b/%b expected 1/1", err, err4);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    n_tests++;
    if (err !== 1'b0 || err4 !== 1'b0) begin
      n_fail++; $display("FAIL err_reset: got %b/%b expected 0/0", err, err4);
    end
    wait_idle(n);
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    for (int i = 0; i < 9; i++) begin
      iWriteEnable = 1'b1; iWriteAddress = 8'(i); iDataIn = 16'(16'h0100 + i);
      tick();
    end
    iWriteEnable = 1'b0;
    rd_addr4 = {8'd7, 8'd6, 8'd1, 8'd0};
    tick();
    n_tests++;
    if (dout4 !== {16'h0107, 16'h0106, 16'h0101, 16'h0100}) begin
      n_fail++; $display("FAIL fill: got %h expected 0107010601010100", dout4);
    end
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    n_tests++;
    if (busy4 !== 1'b1 || dout4 !== 64'h0) begin
      n_fail++; $display("FAIL mid_reset: got busy %b data %h expected 1 0", busy4, dout4);
    end
    Reset = 1'b1;
    wait_idle(n);
    n_tests++;
    if (n !== 9) begin
      n_fail++; $display("FAIL rerun_len: got %0d expected 9", n);
    end
    for (int i = 0; i < 9; i++) begin
      rd_addr4 = {8'(i), 8'(i), 8'(i), 8'(i)};
      tick();
      n_tests++;
      if (dout4 !== 64'h0) begin
        n_fail++; $display("FAIL rerun_zero[%0d]: got %h expected 0", i, dout4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_bypass();
    test_range();
    test_mid_sweep_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_multi_read_port.md
# ram_multi_read_port

Parametrised successor to the dual-read-port data RAM used by the datapath. It is a register-file style memory with:
- `READ_PORTS` independent registered read ports;
- a primary write port and an auxiliary result write port pinned to a parameterised address, in the multiplier-result slot style;
- optional write-to-read bypass;
- range checking;
- a sequential clear engine that zeroes the array after reset or on request.

It sits between the control unit / ALU result bus and the operand fetch stage.

## Interface
- `DATA_WIDTH`, 16, word width in bits
- `ADDR_WIDTH`, 8, address width
- `MEM_DEPTH`, 9, number of words (valid addresses `0..MEM_DEPTH-1`); must be `<= 2**ADDR_WIDTH`
- `READ_PORTS`, 2, number of read ports (1..8)
- `AUX_ADDR`, 8, fixed address written by the auxiliary port; must be `< MEM_DEPTH`
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = read returns old contents
- `Clock`  in  1  single clock, rising edge
- `Reset`  in  1  synchronous, active-low reset
- `iClear`  in  1  pulse: start a clear sweep (ignored while `oBusy`=1)
- `iWriteEnable`  in  1  primary write strobe
- `iWriteAddress`  in  `ADDR_WIDTH`  primary write address
- `iDataIn`  in  `DATA_WIDTH`  primary write data
- `iAuxEnable`  in  1  auxiliary write strobe
- `iDataInAux`  in  `DATA_WIDTH`  auxiliary write data (to `AUX_ADDR`)
- `iReadAddress`  in  `READ_PORTS*ADDR_WIDTH`  packed read addresses; port p = bits `[p*ADDR_WIDTH +: ADDR_WIDTH]`
- `oDataOut`  out  `READ_PORTS*DATA_WIDTH`  packed registered read data, same packing
- `oBusy`  out  1  clear sweep in progress
- `oRangeError`  out  1  sticky: a primary write or read targeted an address `>= MEM_DEPTH`

## Operation
- FSM states: `CLEAR`, `READY`.
- Clear counter width is `ADDR_WIDTH`.
- **Reset low:**
  - state=`CLEAR`, counter=0;
  - `oDataOut`=0, `oBusy`=1, `oRangeError`=0;
  - memory contents undefined until the sweep completes.
- **`CLEAR`:**
  - each edge writes 0 to `Ram[counter]` and increments the counter;
  - on the edge that clears `MEM_DEPTH-1`, go to `READY` and drop `oBusy`;
  - `iWriteEnable`, `iAuxEnable` and `iClear` are ignored;
  - all `oDataOut` lanes are driven to 0;
  - `oRangeError` is not updated.
- **`READY`:** normal operation.
  - `iClear`=1 → counter=0, state=`CLEAR`, `oBusy`=1 on the next edge. No write is performed on that edge, and read outputs go to 0 that edge.
- **Primary write:** `iWriteEnable`=1 with `iWriteAddress < MEM_DEPTH` writes `iDataIn`. An out-of-range write is discarded and sets `oRangeError`.
- **Auxiliary write:** `iAuxEnable`=1 writes `iDataInAux` to `AUX_ADDR`.
- **Both ports to the same address in the same cycle:** the auxiliary port wins; the primary data is lost and no error is flagged.
- **Reads:** each port registers `Ram[addr]`.
  - An out-of-range read returns 0 and sets `oRangeError`.
- **Read hitting a same-cycle write:**
  - `BYPASS`=1: returns the new data, aux taking priority over primary.
  - `BYPASS=0`: returns pre-write contents.
- Multiple ports may read the same address simultaneously with no restriction.
- `oRangeError` is cleared only by `Reset`; `iClear` does not clear it.

## Timing
- Read latency is 1 cycle: address presented before edge N, data valid after edge N.
- Write is visible to a non-bypassed read issued on the following cycle.
- **Clear sweep duration:**
  - after `Reset` is sampled high at edge 1, entries 0..`MEM_DEPTH-1` are cleared at edges 1..`MEM_DEPTH`;
  - `oBusy`=0 after edge `MEM_DEPTH`;
  - the first accepted write is at edge `MEM_DEPTH+1`.
- An `iClear`-started sweep: `oBusy` rises after the accepting edge and stays high for `MEM_DEPTH` further edges.
- **Reset asserted mid-sweep or mid-operation:** the next edge restarts at counter=0 and all outputs return to their reset values.
- `iClear` during `CLEAR` does not restart the counter.
- No combinational path exists from any input to any output.

## Test plan
- **Reset and clear sweep:**
  - stimulus: defaults; hold `Reset`=0 for 3 cycles, then release;
  - `oBusy` stays 1 for exactly 9 cycles;
  - reading all 9 addresses afterwards returns 0x0000;
  - writes attempted during busy have no effect.
- **Write/read basics:**
  - stimulus: write 0x1234 at addr 3, 0xBEEF at addr 5; next cycle read port0=3, port1=5;
  - one cycle later `oDataOut` = {0xBEEF, 0x1234}.
- **Port conflict:**
  - stimulus: same edge, primary writes 0x1111 to addr 8 and aux writes 0x2222;
  - subsequent read of 8 returns 0x2222 and `oRangeError` stays 0.
- **Bypass:**
  - stimulus: write 0xA5A5 to addr 2 while port0 reads 2 (previously 0x0000);
  - `BYPASS`=1 build → 0xA5A5;
  - `BYPASS`=0 build → 0x0000, then 0xA5A5 on the repeat read.
- **Range error:**
  - stimulus: write 0xFFFF to addr 9, then read addr 200;
  - no array word changes, read returns 0, `oRangeError`=1;
  - `oRangeError` persists through an `iClear` sweep and clears only on `Reset`=0.
- **Clear and reset mid-sweep, `READ_PORTS`=4 build:**
  - stimulus: fill the array, pulse `iClear`, assert `Reset` low at sweep cycle 4, release;
  - a full 9-cycle sweep reruns;
  - all four ports read 0 at addresses 0..8.
